// File: rtl/comma_align_deser_if.sv
// Serial-in / aligned-symbol-out bundle for the comma aligner.
// The master drives the serial bit; the slave returns aligned symbols and lock status.
interface comma_align_deser_if;
  logic       serial_in;
  logic [9:0] sym_out;
  logic       sym_valid;
  logic       comma_det;
  logic       locked;

  modport master (
    output serial_in,
    input  sym_out,
    input  sym_valid,
    input  comma_det,
    input  locked
  );

  modport slave (
    input  serial_in,
    output sym_out,
    output sym_valid,
    output comma_det,
    output locked
  );
endinterface

// File: rtl/comma_align_deser.sv
// 1-bit serial to 10-bit deserializer with K28.5 comma alignment.
// A hunt/sync/lock state machine acquires alignment and tolerates isolated bit slips while locked.
module comma_align_deser #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic                clock,
  input  logic                reset,
  comma_align_deser_if.slave  link
);

  localparam int unsigned CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_TH   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_TH = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [9:0] COMMA_NEG = 10'b0011111010;
  localparam logic [9:0] COMMA_POS = 10'b1100000101;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [9:0]       sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [9:0]       sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             comma_q, comma_d;
  logic             comma_hit;
  logic             boundary;
  logic             emit;

  assign comma_hit = (sr_q == COMMA_NEG) || (sr_q == COMMA_POS);
  assign boundary  = (bit_cnt_q == 4'd9);

  always_comb begin
    state_d   = state_q;
    sr_d      = {sr_q[8:0], link.serial_in};
    bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
    good_d    = good_q;
    bad_d     = bad_q;
    emit      = 1'b0;

    case (state_q)
      HUNT: begin
        if (comma_hit) begin
          emit      = 1'b1;
          bit_cnt_d = 4'd0;
          good_d    = CNT_W'(1);
          state_d   = (LOCK_CNT <= 1) ? LOCKED : SYNC;
        end
      end
      SYNC: begin
        if (comma_hit && !boundary) begin
          emit      = 1'b1;
          bit_cnt_d = 4'd0;
          good_d    = CNT_W'(1);
        end else if (boundary) begin
          emit = 1'b1;
          if (comma_hit) begin
            good_d = (good_q == CNT_SAT) ? good_q : good_q + CNT_W'(1);
            if (good_d >= LOCK_TH) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          emit = 1'b1;
          if (comma_hit) bad_d = '0;
        end else if (comma_hit) begin
          // Misaligned comma: keep the current cadence, only count it.
          bad_d = (bad_q == CNT_SAT) ? bad_q : bad_q + CNT_W'(1);
          if (bad_d >= UNLOCK_TH) begin
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    valid_d = emit;
    comma_d = emit & comma_hit;
    sym_d   = emit ? sr_q : sym_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      sym_q     <= '0;
      valid_q   <= 1'b0;
      comma_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      sym_q     <= sym_d;
      valid_q   <= valid_d;
      comma_q   <= comma_d;
    end
  end

  assign link.sym_out   = sym_q;
  assign link.sym_valid = valid_q;
  assign link.comma_det = comma_q;
  assign link.locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_comma_align_deser.sv
// Directed bench for comma_align_deser: expected emissions (symbol, comma flag,
// lock state, edge number) are queued as bits are driven and checked on each strobe.
module tb_comma_align_deser;

  logic clock;
  logic reset;
  int   cyc = 0;
  int   ncmp = 0;
  int   nmis = 0;

  typedef struct {
    logic [9:0] sym;
    logic       cd;
    logic       lk;
    int         cyc;
  } exp_t;

  exp_t q[$];

  comma_align_deser_if link();

  comma_align_deser #(.LOCK_CNT(3), .UNLOCK_CNT(4)) dut (
    .clock (clock),
    .reset (reset),
    .link  (link)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (link.sym_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {22'd0, link.sym_out}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sym_out",   {22'd0, link.sym_out}, {22'd0, e.sym});
        chk("comma_det", {31'd0, link.comma_det}, {31'd0, e.cd});
        chk("locked",    {31'd0, link.locked}, {31'd0, e.lk});
        chk("strobe_edge", cyc, e.cyc);
      end
    end else begin
      chk("comma_det_unqualified", {31'd0, link.comma_det}, 32'd0);
    end
  end

  task automatic drive(input logic b);
    link.serial_in = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [9:0] v, input int unsigned n);
    logic [9:0] t;
    t = v;
    for (int unsigned i = n; i > 0; i--) drive(t[i-1]);
  endtask

  task automatic expect_at(input logic [9:0] s, input logic cd, input logic lk, input int edge_n);
    exp_t e;
    e.sym = s; e.cd = cd; e.lk = lk; e.cyc = edge_n;
    q.push_back(e);
  endtask

  // Aligned symbol: last bit sampled 10 edges out, strobe one edge later.
  task automatic send_aligned(input logic [9:0] s, input logic cd, input logic lk);
    expect_at(s, cd, lk, cyc + 11);
    send_bits(s, 10);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, link.sym_valid}, 32'd0);
    chk({tag, "_sym"},   {22'd0, link.sym_out}, 32'd0);
    chk({tag, "_comma"}, {31'd0, link.comma_det}, 32'd0);
    chk({tag, "_locked"},{31'd0, link.locked}, 32'd0);
  endtask

  initial begin
    int cs;
    reset = 1'b0;
    link.serial_in = 1'b1;

    // Reset held with ones on the line.
    for (int i = 0; i < 20; i++) drive(1'b1);
    check_idle_outputs("reset");
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1);
      chk("post_reset_quiet", {31'd0, link.sym_valid}, 32'd0);
    end

    // Junk, then first comma acquired in HUNT.
    send_bits(10'b010, 3);
    send_aligned(10'h0FA, 1'b1, 1'b0);
    chk("hunt_no_early_strobe", {31'd0, link.sym_valid}, 32'd0);
    drive(1'b1);
    chk("first_comma_valid", {31'd0, link.sym_valid}, 32'd1);
    chk("first_comma_sym", {22'd0, link.sym_out}, 32'h0FA);
    chk("first_comma_unlocked", {31'd0, link.locked}, 32'd0);
    // The bit above was the first bit of D21.5 (0x2AA); finish it.
    expect_at(10'h2AA, 1'b0, 1'b0, cyc + 10);
    send_bits(10'h2AA, 9);
    send_aligned(10'h305, 1'b1, 1'b0);
    send_aligned(10'h2AA, 1'b0, 1'b0);
    send_aligned(10'h0FA, 1'b1, 1'b1);

    // One-bit slip while locked: four misaligned commas, old cadence kept.
    drive(1'b0);
    chk("locked_after_third", {31'd0, link.locked}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      expect_at(10'h07D, 1'b0, 1'b1, cyc + 10);
      send_bits(10'h0FA, 10);
    end
    cs = cyc;
    expect_at(10'h0FA, 1'b1, 1'b0, cs + 11);
    drive(1'b0);
    chk("unlock_on_fourth", {31'd0, link.locked}, 32'd0);
    chk("unlock_edge_no_emit", {31'd0, link.sym_valid}, 32'd0);
    send_bits(10'h0FA, 9);

    // SYNC with two aligned commas, then a 3-bit slip forces realign.
    send_aligned(10'h2AA, 1'b0, 1'b0);
    send_aligned(10'h305, 1'b1, 1'b0);
    expect_at(10'h29F, 1'b0, 1'b0, cyc + 11);
    send_bits(10'b101, 3);
    send_aligned(10'h0FA, 1'b1, 1'b0);
    send_aligned(10'h305, 1'b1, 1'b0);
    send_aligned(10'h2AA, 1'b0, 1'b0);
    send_aligned(10'h0FA, 1'b1, 1'b1);

    // Asynchronous reset mid-symbol while locked.
    expect_at(10'h2AA, 1'b0, 1'b1, cyc + 11);
    send_bits(10'h2AA, 10);
    send_bits(10'h305 >> 6, 4);
    chk("locked_before_reset", {31'd0, link.locked}, 32'd1);
    reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    for (int i = 0; i < 3; i++) drive(1'b0);
    #2 reset = 1'b1;
    send_bits(10'h305, 6);
    send_bits(10'h2AA, 10);
    chk("no_reacquire_without_comma", {31'd0, link.locked}, 32'd0);
    send_aligned(10'h0FA, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
